// File: rtl/axis_hit_detector.sv
// ----------------------------------------------------------------------------
// axis_hit_detector
//
// Turns one channel's magnitude stream into discrete drum-hit events. A strike
// starts when a sample reaches the onset threshold. It ends when a sample falls
// below the effective release threshold, which is min(off, on). During the
// strike the block tracks the peak magnitude and a saturating duration. When the
// strike ends it emits one event {duration, peak}. It then ignores cfg_holdoff
// valid samples before it can detect another onset.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   magnitude_tdata     unsigned magnitude sample
//   magnitude_tvalid    sample valid (no back-pressure; every valid is used)
//   cfg_threshold_on    onset threshold
//   cfg_threshold_off   release threshold (clamped to <= on)
//   cfg_holdoff         valid samples ignored after a strike
//   m_axis_tdata        event {duration, peak}
//   m_axis_tvalid       event valid
//   m_axis_tready       downstream ready
//   dropped_count       saturating count of events lost to a full register
//   active              high while a strike is in progress
//
// AXIS_TDATA_WIDTH must equal MAG_WIDTH + DUR_WIDTH.
// ----------------------------------------------------------------------------
module axis_hit_detector #(
    parameter int MAG_WIDTH        = 24,
    parameter int DUR_WIDTH        = 8,
    parameter int HOLD_WIDTH       = 16,
    parameter int AXIS_TDATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [MAG_WIDTH-1:0]        magnitude_tdata,
    input  logic                        magnitude_tvalid,
    input  logic [MAG_WIDTH-1:0]        cfg_threshold_on,
    input  logic [MAG_WIDTH-1:0]        cfg_threshold_off,
    input  logic [HOLD_WIDTH-1:0]       cfg_holdoff,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [7:0]                  dropped_count,
    output logic                        active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    function automatic logic [DUR_WIDTH-1:0] sat_inc_dur(input logic [DUR_WIDTH-1:0] d);
        return (d == {DUR_WIDTH{1'b1}}) ? d : d + DUR_WIDTH'(1);
    endfunction

    function automatic logic [7:0] sat_inc_drop(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    state_t                        state_q, state_d;
    logic [MAG_WIDTH-1:0]          peak_q, peak_d;
    logic [DUR_WIDTH-1:0]          dur_q, dur_d;
    logic [HOLD_WIDTH-1:0]         hold_q, hold_d;
    logic                          active_q;
    logic                          tvalid_q, tvalid_d;
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [7:0]                    drop_q, drop_d;

    logic [MAG_WIDTH-1:0]          thr_off;
    logic                          ev_gen;
    logic [AXIS_TDATA_WIDTH-1:0]   ev_word;

    // A release threshold above the onset threshold would end a strike
    // immediately. Clamping it to the onset threshold keeps the hysteresis sane.
    assign thr_off = (cfg_threshold_off < cfg_threshold_on) ? cfg_threshold_off
                                                            : cfg_threshold_on;

    // The event reports the strike as it stood before the release sample.
    assign ev_word = {dur_q, peak_q};

    // Strike state machine: only valid samples advance it.
    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        dur_d   = dur_q;
        hold_d  = hold_q;
        ev_gen  = 1'b0;
        if (magnitude_tvalid) begin
            unique case (state_q)
                IDLE: begin
                    if (magnitude_tdata >= cfg_threshold_on) begin
                        state_d = ATTACK;
                        peak_d  = magnitude_tdata;
                        dur_d   = DUR_WIDTH'(1);
                    end
                end
                ATTACK: begin
                    if (magnitude_tdata >= thr_off) begin
                        if (magnitude_tdata > peak_q) begin
                            peak_d = magnitude_tdata;
                        end
                        dur_d = sat_inc_dur(dur_q);
                    end else begin
                        ev_gen  = 1'b1;
                        hold_d  = cfg_holdoff;
                        state_d = (cfg_holdoff == '0) ? IDLE : HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    hold_d = hold_q - HOLD_WIDTH'(1);
                    // The counter is nonzero on entry, so the sample that
                    // brings it to zero is the last one ignored.
                    if (hold_q <= HOLD_WIDTH'(1)) begin
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Single-entry output register. A slot that is draining this cycle
    // counts as free, so back-to-back events at full throughput are not lost.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        drop_d   = drop_q;
        if (ev_gen) begin
            if (!tvalid_q || m_axis_tready) begin
                tvalid_d = 1'b1;
                tdata_d  = ev_word;
            end else begin
                drop_d = sat_inc_drop(drop_q);
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            peak_q   <= '0;
            dur_q    <= '0;
            hold_q   <= '0;
            active_q <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            peak_q   <= peak_d;
            dur_q    <= dur_d;
            hold_q   <= hold_d;
            active_q <= (state_d == ATTACK);
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            drop_q   <= drop_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign dropped_count = drop_q;
    assign active        = active_q;

endmodule

// File: tb/tb_axis_hit_detector.sv
module tb_axis_hit_detector;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [23:0] magnitude_tdata = '0;
    logic        magnitude_tvalid = 1'b0;
    logic [23:0] cfg_threshold_on = 24'd1000;
    logic [23:0] cfg_threshold_off = 24'd600;
    logic [15:0] cfg_holdoff = 16'd4;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [7:0]  dropped_count;
    logic        active;

    axis_hit_detector dut (
        .aclk              (aclk),
        .areset            (areset),
        .magnitude_tdata   (magnitude_tdata),
        .magnitude_tvalid  (magnitude_tvalid),
        .cfg_threshold_on  (cfg_threshold_on),
        .cfg_threshold_off (cfg_threshold_off),
        .cfg_holdoff       (cfg_holdoff),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .dropped_count     (dropped_count),
        .active            (active)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                         name, act, act, exp, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one strike record plus a holdoff budget, and a
    // one-slot mailbox toward the host. Transferred events are logged.
    // ------------------------------------------------------------------
    bit          m_strike = 0;
    int          m_hold   = 0;
    int          m_peak   = 0;
    int          m_dur    = 0;
    bit          m_active = 0;
    bit          m_full   = 0;
    logic [31:0] m_word   = '0;
    int          m_drop   = 0;
    logic [31:0] ev_log[$];
    bit          chk_en   = 0;

    always @(posedge aclk) begin
        bit          emit;
        logic [31:0] ew;
        int          mag, on, off;
        chk_en <= 1'b1;
        if (areset) begin
            m_strike = 0; m_hold = 0; m_peak = 0; m_dur = 0;
            m_active = 0; m_full = 0; m_word = '0; m_drop = 0;
        end else begin
            emit = 0;
            ew   = '0;
            mag  = int'(magnitude_tdata);
            on   = int'(cfg_threshold_on);
            off  = int'(cfg_threshold_off);
            if (off > on) off = on;
            if (magnitude_tvalid) begin
                if (m_hold > 0) begin
                    m_hold = m_hold - 1;
                end else if (m_strike) begin
                    if (mag >= off) begin
                        if (mag > m_peak) m_peak = mag;
                        if (m_dur < 255) m_dur = m_dur + 1;
                    end else begin
                        emit     = 1;
                        ew       = {m_dur[7:0], m_peak[23:0]};
                        m_strike = 0;
                        m_hold   = int'(cfg_holdoff);
                    end
                end else if (mag >= on) begin
                    m_strike = 1;
                    m_peak   = mag;
                    m_dur    = 1;
                end
            end
            if (m_full && m_axis_tready) begin
                ev_log.push_back(m_word);
                m_full = 0;
            end
            if (emit) begin
                if (!m_full) begin
                    m_full = 1;
                    m_word = ew;
                end else if (m_drop < 255) begin
                    m_drop = m_drop + 1;
                end
            end
            m_active = m_strike;
        end
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            check("tvalid", {31'd0, m_axis_tvalid}, {31'd0, m_full});
            if (m_full) check("tdata", m_axis_tdata, m_word);
            check("dropped", {24'd0, dropped_count}, m_drop);
            check("active", {31'd0, active}, {31'd0, m_active});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic send(input logic v, input int m);
        magnitude_tvalid = v;
        magnitude_tdata  = m[23:0];
        @(negedge aclk);
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 0);
    endtask

    initial begin
        int base;
        send(1'b0, 0);
        send(1'b0, 0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_dropped", {24'd0, dropped_count}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        areset = 1'b0;

        // Basic strike
        base = ev_log.size();
        send(1'b1, 0);
        send(1'b1, 1200);
        check("t1_active1", {31'd0, active}, 32'd1);
        send(1'b1, 1500);
        send(1'b1, 900);
        check("t1_active3", {31'd0, active}, 32'd1);
        send(1'b1, 500);
        check("t1_active_off", {31'd0, active}, 32'd0);
        check("t1_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        check("t1_tdata", m_axis_tdata, {8'd3, 24'd1500});
        zeros(4);
        check("t1_count", ev_log.size() - base, 32'd1);
        check("t1_log", ev_log[base], {8'd3, 24'd1500});

        // Holdoff ignores loud samples
        base = ev_log.size();
        send(1'b1, 1200);
        send(1'b1, 500);
        send(1'b1, 2000);
        send(1'b1, 2000);
        check("t2_hold_inactive", {31'd0, active}, 32'd0);
        send(1'b1, 0);
        send(1'b1, 0);
        send(1'b1, 1100);
        send(1'b1, 300);
        zeros(4);
        check("t2_count", ev_log.size() - base, 32'd2);
        check("t2_ev0", ev_log[base], {8'd1, 24'd1200});
        check("t2_ev1", ev_log[base+1], {8'd1, 24'd1100});

        // Duration saturation
        base = ev_log.size();
        for (int i = 0; i < 300; i++) send(1'b1, 1000);
        send(1'b1, 0);
        check("t3_tdata", m_axis_tdata, {8'd255, 24'd1000});
        zeros(4);
        check("t3_log", ev_log[base], {8'd255, 24'd1000});

        // Pending event drains in the same cycle a new one arrives
        m_axis_tready = 1'b0;
        send(1'b1, 1200);
        send(1'b1, 500);
        zeros(4);
        send(1'b1, 1500);
        m_axis_tready = 1'b1;
        base = ev_log.size();
        send(1'b1, 500);
        check("t5_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        check("t5_tdata", m_axis_tdata, {8'd1, 24'd1500});
        check("t5_dropped", {24'd0, dropped_count}, 32'd0);
        check("t5_old_xfer", ev_log[base], {8'd1, 24'd1200});
        zeros(4);

        // Drops while the register is stuck
        m_axis_tready = 1'b0;
        send(1'b1, 1200);
        send(1'b1, 500);
        zeros(4);
        send(1'b1, 1300);
        send(1'b1, 500);
        check("t4_dropped1", {24'd0, dropped_count}, 32'd1);
        check("t4_held", m_axis_tdata, {8'd1, 24'd1200});
        zeros(4);
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 1200);
            send(1'b1, 500);
            zeros(4);
        end
        check("t4_dropped_sat", {24'd0, dropped_count}, 32'd255);
        check("t4_held2", m_axis_tdata, {8'd1, 24'd1200});

        // Reset mid-strike with a pending event
        send(1'b1, 1200);
        check("t6_active_pre", {31'd0, active}, 32'd1);
        areset = 1'b1;
        send(1'b0, 0);
        areset = 1'b0;
        check("t6_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t6_active", {31'd0, active}, 32'd0);
        check("t6_dropped", {24'd0, dropped_count}, 32'd0);
        m_axis_tready = 1'b1;
        cfg_threshold_off = 24'd2000;
        send(1'b1, 1200);
        check("t6_restart", {31'd0, active}, 32'd1);
        send(1'b1, 1100);
        send(1'b1, 999);
        check("t6_tdata", m_axis_tdata, {8'd2, 24'd1200});
        cfg_threshold_off = 24'd600;
        zeros(4);

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                cfg_threshold_on  = 24'($urandom_range(800, 1200));
                cfg_threshold_off = 24'($urandom_range(400, 1500));
                cfg_holdoff       = 16'($urandom_range(0, 5));
            end
            m_axis_tready = ($urandom_range(0, 3) != 0);
            areset = ($urandom_range(0, 799) == 0);
            send($urandom_range(0, 4) != 0, $urandom_range(0, 1600));
        end
        areset = 1'b0;
        send(1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
